dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipelined processor's MEM-stage port
//  (MemRead/MemWrite/Addr/Din/Dout) and an external requester (DMA/loader/debug).
//  CPU has priority. External gets idle cycles, a forced slot after MAX_WAIT, and bounded bursts.
//  Sits between processor, external master and data memory; stalls the CPU when it loses a cycle.
// PARAMETERS
//  AW        32  address width (byte address; memory indexes Addr>>2)
//  DW        32  data width
//  MAX_WAIT  8   ext cycles waiting while CPU busy before a forced ext slot (>=1)
//  MAX_BURST 4   max consecutive ext grants under ext_lock before 1 cycle is reserved for CPU (>=1)
// PORTS
//  clock      in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-low (0 = in reset)
//  cpu_re     in   1   CPU MemRead
//  cpu_we     in   1   CPU MemWrite
//  cpu_addr   in   AW  CPU Addr
//  cpu_wdata  in   DW  CPU Din
//  cpu_rdata  out  DW  CPU Dout (combinational from mem_dout)
//  cpu_stall  out  1   CPU must hold its MEM-stage access this cycle
//  ext_req    in   1   ext access request, held until ext_gnt
//  ext_we     in   1   1 = write, 0 = read
//  ext_lock   in   1   request burst ownership
//  ext_addr   in   AW  ext byte address
//  ext_wdata  in   DW  ext write data
//  ext_gnt    out  1   ext access issued this cycle
//  ext_rdata  out  DW  registered read data
//  ext_rvalid out  1   ext_rdata valid, 1 cycle after a granted read
//  mem_re     out  1   memory read enable
//  mem_we     out  1   memory write enable (memory writes at posedge)
//  mem_addr   out  AW  memory byte address
//  mem_wdata  out  DW  memory write data
//  mem_dout   in   DW  memory read data (combinational)
// BEHAVIOUR
//  - cpu_act = cpu_re|cpu_we. One owner per cycle; owner's signals muxed onto mem_*; if no
//    owner, mem_re=mem_we=0, mem_addr/mem_wdata=0.
//  - States: IDLE (CPU owner whenever cpu_act), EXT_BURST, CPU_RSV. Regs: wait_cnt, burst_cnt.
//  - IDLE: ext_gnt=ext_req & (~cpu_act | wait_cnt==MAX_WAIT). Otherwise CPU owns.
//    wait_cnt++ each cycle ext_req & ~ext_gnt, saturates at MAX_WAIT; cleared on any ext_gnt.
//    ext_gnt & ext_lock -> EXT_BURST, burst_cnt=1.
//  - EXT_BURST: ext owns every cycle ext_req; CPU stalled if cpu_act. burst_cnt++ per grant.
//    ext_lock=0 or ext_req=0 -> IDLE. burst_cnt==MAX_BURST at a grant -> CPU_RSV.
//  - CPU_RSV: exactly 1 cycle, ext_gnt=0, CPU owns (if cpu_act), then IDLE; wait_cnt not incremented.
//  - cpu_stall = cpu_act & ext_gnt. cpu_rdata = mem_dout every cycle (valid when CPU owns).
//  - ext_rvalid <= ext_gnt & ~ext_we; ext_rdata <= mem_dout captured on that grant, else held.
//  - Simultaneous CPU/ext at wait_cnt==MAX_WAIT: ext wins, CPU stalls exactly 1 cycle (unless lock).
//  - cpu_re & cpu_we both 1: treated as write (mem_we=1, mem_re=0).
//  - Reset (async, reset==0): state=IDLE, counters 0, ext_rvalid=0, ext_rdata=0; combinational
//    outputs follow IDLE rules. Reset mid-burst aborts; a pending ext_rvalid is dropped.
//  - Latency: CPU read 0 cycles (same as direct memory); ext read 1 cycle after ext_gnt.
// STRUCTURE
//  - Package dmem_arb_pkg: state enum {IDLE, EXT_BURST, CPU_RSV}, default AW/DW.
//  - Single module; optional sub-module arb_sat_counter (saturating up-counter, clear/inc) used
//    for wait_cnt and burst_cnt. Muxes and stall combinational; FSM, counters, ext_rdata registered.
// TESTING
//  - CPU-only: cpu_we addr 0x8 data 0x9, then cpu_re 0x8 -> mem_we then cpu_rdata=0x9,
//    cpu_stall never 1, ext_gnt=0.
//  - Ext in idle: cpu idle, ext_req read 0x4 (mem[1]=0x8) -> ext_gnt same cycle, next cycle
//    ext_rvalid=1, ext_rdata=0x8.
//  - Starvation: cpu_act every cycle, ext_req held, MAX_WAIT=8 -> ext_gnt on 9th cycle,
//    cpu_stall=1 that cycle only, wait_cnt then 0.
//  - Burst: ext_lock=1, 6 writes, CPU busy, MAX_BURST=4 -> 4 consecutive grants, 1 CPU_RSV cycle
//    (cpu_stall=0), then burst resumes as IDLE/forced rules apply.
//  - Reset mid-burst: drive reset=0 during EXT_BURST grant 2 -> ext_rvalid=0, state IDLE,
//    counters 0 immediately (async); after release CPU access proceeds unstalled.
//  - Collision re/we: cpu_re=cpu_we=1 -> mem_we=1, mem_re=0; write lands.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the CPU MEM stage
// and an external master.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXT_BURST = 2'd1,
    CPU_RSV   = 2'd2
  } arb_state_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear; clear and increment together load 1 so a
// first event can be counted in the same cycle that restarts the count.
module arb_sat_counter #(
  parameter int MAXV = 8,
  parameter int W    = $clog2(MAXV + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] TOP = W'(MAXV);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != TOP)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has priority, the external master gets idle
// cycles, a forced slot after MAX_WAIT stalled cycles, and bounded locked bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_lock,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_dout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_TOP   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_e    state_q;
  logic          ext_rvalid_q;
  logic [DW-1:0] ext_rdata_q;

  logic          cpu_act;
  logic          gnt;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          wait_clr, wait_inc;
  logic          burst_clr, burst_inc;

  assign cpu_act = cpu_re | cpu_we;

  always_comb begin
    gnt = 1'b0;
    case (state_q)
      IDLE:      gnt = ext_req & (~cpu_act | (wait_cnt == WAIT_TOP));
      EXT_BURST: gnt = ext_req;
      default:   gnt = 1'b0;
    endcase
  end

  // The reserved CPU cycle neither grants nor ages the external request.
  assign wait_clr  = gnt;
  assign wait_inc  = ext_req & ~gnt & (state_q != CPU_RSV);
  assign burst_clr = (state_q != EXT_BURST);
  assign burst_inc = gnt & (((state_q == IDLE) & ext_lock) | (state_q == EXT_BURST));

  arb_sat_counter #(.MAXV(MAX_WAIT), .W(WW)) u_wait_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (wait_clr),
    .inc_i  (wait_inc),
    .cnt_o  (wait_cnt)
  );

  arb_sat_counter #(.MAXV(MAX_BURST), .W(BW)) u_burst_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (burst_clr),
    .inc_i  (burst_inc),
    .cnt_o  (burst_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      ext_rvalid_q <= gnt & ~ext_we;
      if (gnt && !ext_we) begin
        ext_rdata_q <= mem_dout;
      end
      case (state_q)
        IDLE: begin
          if (gnt && ext_lock) begin
            state_q <= (MAX_BURST == 1) ? CPU_RSV : EXT_BURST;
          end
        end
        EXT_BURST: begin
          // burst_cnt still holds the count before this cycle's grant.
          if (!ext_req || !ext_lock) begin
            state_q <= IDLE;
          end else if (burst_cnt == BURST_LAST) begin
            state_q <= CPU_RSV;
          end
        end
        CPU_RSV: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt) begin
      mem_re    = ~ext_we;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (cpu_act) begin
      mem_re    = cpu_re & ~cpu_we;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign ext_gnt    = gnt;
  assign cpu_stall  = cpu_act & gnt;
  assign cpu_rdata  = mem_dout;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

endmodule
